// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited request issue, in-order response tracking,
// and a DEPTH-entry instruction queue with redirect flush and stale-response discard.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [31:0]              imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [$clog2(DEPTH):0]   queue_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] RST_PC = RESET_PC & ~32'h3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          q_mem [DEPTH];
  logic [31:0]     fetch_pc, rsp_pc;
  logic [CW-1:0]   outstanding, discard_cnt, outstanding_nxt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW:0]     credits_used;
  logic            req_fire, rsp_take, rsp_drop, enq, deq;

  // Credits cover both queued entries and in-flight fetches, so the queue cannot overflow.
  assign credits_used   = {1'b0, outstanding} + {1'b0, queue_count};
  assign imem_req_valid = !reset && !redirect_valid && (credits_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_take = imem_rsp_valid && (outstanding != '0);
  assign rsp_drop = redirect_valid || (discard_cnt != '0);
  assign enq      = rsp_take && !rsp_drop;
  assign deq      = out_valid && out_ready;

  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_take);

  assign out_valid = (queue_count != '0);
  assign out_instr = q_mem[rd_ptr].instr;
  assign out_pc    = q_mem[rd_ptr].pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RST_PC;
      rsp_pc      <= RST_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      queue_count <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        // No request fires while redirecting, so outstanding_nxt is the post-response count.
        fetch_pc    <= redirect_pc & ~32'h3;
        rsp_pc      <= redirect_pc & ~32'h3;
        queue_count <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        discard_cnt <= outstanding_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (enq) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (deq) rd_ptr <= rd_ptr + 1'b1;
        queue_count <= queue_count + CW'(enq) - CW'(deq);
        if (rsp_take && discard_cnt != '0) discard_cnt <= discard_cnt - 1'b1;
      end
    end
  end

  // Storage needs no reset; validity is carried entirely by queue_count.
  always_ff @(posedge clk) begin
    if (enq) q_mem[wr_ptr] <= '{pc: rsp_pc, instr: imem_rsp_data};
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a latency-modelled memory plus a queue-based
// reference of what decode should see, with scenario tasks for the key behaviours.
module tb_fetch_stage;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_instr, out_pc;
  logic [2:0]  queue_count;

  logic        w_req_valid, w_out_valid;
  logic [31:0] w_req_addr, w_out_instr, w_out_pc;
  logic [2:0]  w_queue_count;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .queue_count(queue_count));

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .reset(reset), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
    .out_valid(w_out_valid), .out_ready(1'b0), .out_instr(w_out_instr), .out_pc(w_out_pc),
    .queue_count(w_queue_count));

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  pend_t       pend[$];   // requests the memory has accepted, in order
  logic [31:0] mq[$];     // pcs decode should see, head first
  logic [31:0] m_fetch;
  int          cyc, lat_min, lat_max, dut_fires;
  int          n_cmp, n_err;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: drive inputs, score the DUT against the reference, advance both.
  task automatic tick(input bit redir, input logic [31:0] tgt, input bit rdy, input bit ordy);
    bit    rsp, exp_rv, fire, deq;
    pend_t p;
    rsp = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_fn(pend[0].addr) : $urandom;
    redirect_valid = redir;
    redirect_pc    = tgt;
    imem_req_ready = rdy;
    out_ready      = ordy;
    #1;
    exp_rv = !redir && (pend.size() + mq.size() < DEPTH);
    n_cmp++;
    if (imem_req_valid !== exp_rv) begin
      n_err++; $display("FAIL sb_req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_rv);
    end
    if (exp_rv) begin
      n_cmp++;
      if (imem_req_addr !== m_fetch) begin
        n_err++; $display("FAIL sb_req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, m_fetch);
      end
    end
    n_cmp++;
    if (out_valid !== (mq.size() != 0) || queue_count !== 3'(mq.size())) begin
      n_err++; $display("FAIL sb_queue cyc=%0d got v=%b n=%0d exp n=%0d", cyc, out_valid, queue_count, mq.size());
    end
    if (mq.size() > 0) begin
      n_cmp++;
      if (out_pc !== mq[0] || out_instr !== mem_fn(mq[0])) begin
        n_err++; $display("FAIL sb_head cyc=%0d got pc=%h ins=%h exp pc=%h ins=%h",
                          cyc, out_pc, out_instr, mq[0], mem_fn(mq[0]));
      end
    end
    if (imem_req_valid && rdy) dut_fires++;
    fire = exp_rv && rdy;
    deq  = (mq.size() > 0) && ordy;
    @(posedge clk);
    if (rsp) p = pend.pop_front();
    if (redir) mq.delete();
    else begin
      if (deq) void'(mq.pop_front());
      if (rsp && !p.stale) mq.push_back(p.addr);
    end
    if (redir) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      m_fetch = tgt & ~32'h3;
    end else if (fire) begin
      pend.push_back('{addr: m_fetch, due: cyc + int'($urandom_range(lat_min, lat_max)), stale: 1'b0});
      m_fetch += 32'd4;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b0; out_ready = 1'b0;
    pend.delete(); mq.delete(); m_fetch = 32'h0; cyc = 0; dut_fires = 0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (imem_req_valid !== 1'b0 || out_valid !== 1'b0 || queue_count !== 3'd0 || imem_req_addr !== 32'h0) begin
      n_err++; $display("FAIL reset_hold got rv=%b ov=%b n=%0d a=%h exp 0/0/0/0", imem_req_valid, out_valid, queue_count, imem_req_addr);
    end
    do_reset();
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_err++; $display("FAIL reset_first_req got rv=%b a=%h exp 1/00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int c = 0; c < 20; c++) begin
      if (c >= 2) begin
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 32'(4 * (c - 2))) begin
          n_err++; $display("FAIL stream_seq c=%0d got v=%b pc=%h exp 1/%h", c, out_valid, out_pc, 32'(4 * (c - 2)));
        end
      end
      tick(0, 32'h0, 1, 1);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int c = 0; c < 8; c++) tick(0, 32'h0, 1, 0);
    #1;
    n_cmp++;
    if (dut_fires != 4 || imem_req_valid !== 1'b0 || queue_count !== 3'd4) begin
      n_err++; $display("FAIL bp_fill got fires=%0d rv=%b n=%0d exp 4/0/4", dut_fires, imem_req_valid, queue_count);
    end
    dut_fires = 0;
    tick(0, 32'h0, 1, 1);
    for (int c = 0; c < 5; c++) tick(0, 32'h0, 1, 0);
    n_cmp++;
    if (dut_fires != 1) begin
      n_err++; $display("FAIL bp_one_more got fires=%0d exp 1", dut_fires);
    end
  endtask

  task automatic test_redirect_inflight();
    bit seen;
    do_reset();
    lat_min = 4; lat_max = 4;
    tick(0, 32'h0, 1, 1);
    tick(0, 32'h0, 1, 1);
    tick(1, 32'h0000_0103, 1, 1);
    redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      n_err++; $display("FAIL redir_addr got rv=%b a=%h exp 1/00000100", imem_req_valid, imem_req_addr);
    end
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      #1;
      if (out_valid) seen = 1;
      else tick(0, 32'h0, 1, 0);
    end
    n_cmp++;
    if (!seen || out_pc !== 32'h100) begin
      n_err++; $display("FAIL redir_first_pc got seen=%0d pc=%h exp 1/00000100", seen, out_pc);
    end
  endtask

  task automatic test_redirect_coincident();
    int exp_disc;
    bit seen;
    do_reset();
    lat_min = 2; lat_max = 2;
    for (int c = 0; c < 6; c++) tick(0, 32'h0, 1, 1);
    n_cmp++;
    if (!(mq.size() > 0 && pend.size() > 1 && pend[0].due <= cyc)) begin
      n_err++; $display("FAIL coin_setup got mq=%0d pend=%0d exp head+rsp+inflight", mq.size(), pend.size());
    end
    exp_disc = pend.size() - 1;
    tick(1, 32'h0000_0200, 1, 1);
    redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if (queue_count !== 3'd0 || out_valid !== 1'b0 || dut.discard_cnt !== 3'(exp_disc)) begin
      n_err++; $display("FAIL coin_flush got n=%0d v=%b disc=%0d exp 0/0/%0d", queue_count, out_valid, dut.discard_cnt, exp_disc);
    end
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      #1;
      if (out_valid) seen = 1;
      else tick(0, 32'h0, 1, 1);
    end
    n_cmp++;
    if (!seen || out_pc !== 32'h200) begin
      n_err++; $display("FAIL coin_first_pc got seen=%0d pc=%h exp 1/00000200", seen, out_pc);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    lat_min = 1; lat_max = 2;
    for (int c = 0; c < 6; c++) tick(0, 32'h0, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b0 || queue_count !== 3'd0) begin
      n_err++; $display("FAIL midreset_async got v=%b rv=%b n=%0d exp 0/0/0", out_valid, imem_req_valid, queue_count);
    end
    do_reset();
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_err++; $display("FAIL midreset_restart got rv=%b a=%h exp 1/00000000", imem_req_valid, imem_req_addr);
    end
    for (int c = 0; c < 10; c++) tick(0, 32'h0, 1, 1);
  endtask

  task automatic test_wrap();
    logic [31:0] wexp [3];
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (w_req_valid !== 1'b1 || w_req_addr !== wexp[i]) begin
        n_err++; $display("FAIL wrap_addr i=%0d got rv=%b a=%h exp 1/%h", i, w_req_valid, w_req_addr, wexp[i]);
      end
      tick(0, 32'h0, 1, 1);
    end
  endtask

  task automatic test_random();
    do_reset();
    lat_min = 1; lat_max = 3;
    for (int c = 0; c < 1500; c++)
      tick($urandom_range(0, 29) == 0, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; lat_min = 1; lat_max = 1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_coincident();
    test_reset_midstream();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
